mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter SIZE, default 32, data/address width.
REQ-002 Parameter TIMEOUT, default 16, max WAIT cycles before abort (used only with MEM_TIMEOUT_EN).
REQ-003 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-004 RST_N  in  1  reset, synchronous, active-low.
REQ-005 PCSrcM, RegWriteM, MemToRegM, MemWriteM  in  1 each  M-stage controls from EX/MEM register.
REQ-006 WA3M  in  4  M-stage destination register.
REQ-007 ALUOutM  in  SIZE  ALU result / memory address.
REQ-008 WriteDataM  in  SIZE  store data.
REQ-009 MemReq  out  1  data memory request.
REQ-010 MemWe  out  1  request is a write.
REQ-011 MemAddr, MemWData  out  SIZE each  request address and store data.
REQ-012 MemRData  in  SIZE  load data, valid with MemAck.
REQ-013 MemAck  in  1  one-cycle completion pulse from memory.
REQ-014 StallM  out  1  holds EX/MEM and all upstream stages.
REQ-015 PCSrcW, RegWriteW, MemToRegW  out  1 each  W-stage controls.
REQ-016 WA3W  out  4; ReadDataW, ALUOutW  out  SIZE each  W-stage data.
REQ-017 MemErr  out  1  sticky timeout flag.

Function
REQ-018 Memory op in M defined as MemToRegM | MemWriteM.
REQ-019 FSM states IDLE, WAIT; IDLE with memory op -> WAIT; WAIT with MemAck -> IDLE; otherwise hold.
REQ-020 MemReq registered: high exactly while state is WAIT; MemWe = MemWriteM, MemAddr = ALUOutM, MemWData = WriteDataM, stable while MemReq high.
REQ-021 StallM combinational: 1 when (IDLE & memory op) or (WAIT & !MemAck), else 0.
REQ-022 Non-memory op: W register loads M fields on next edge, ReadDataW = 0, latency 1 cycle, no stall.
REQ-023 Memory op: W register loads M fields on the edge where WAIT & MemAck; ReadDataW = MemRData for loads, 0 for stores; minimum M-stage occupancy 2 cycles.
REQ-024 While StallM = 1, W register loads a bubble: RegWriteW = PCSrcW = MemToRegW = 0, WA3W = 0, data = 0; no duplicate writeback.
REQ-025 MemAck in IDLE ignored; MemAck and timeout on same cycle: MemAck wins.
REQ-026 Store with ack: RegWriteW follows RegWriteM (normally 0), MemToRegW follows MemToRegM.

Reset
REQ-027 RST_N = 0 at posedge: state IDLE, MemReq 0, all W outputs 0, MemErr 0, timeout counter 0.
REQ-028 Reset during WAIT aborts access; MemReq low from next cycle; late MemAck after reset ignored.

Configuration
REQ-029 Macro MEM_TIMEOUT_EN defined: counter increments each WAIT cycle without MemAck; on reaching TIMEOUT -> IDLE, MemReq drops, W gets bubble, StallM released that cycle, MemErr set and held until reset.
REQ-030 MEM_TIMEOUT_EN undefined: no counter, WAIT held indefinitely, MemErr tied 0.

Structure
REQ-031 Package mem_stage_pkg holds state typedef (IDLE, WAIT) and constant REG_ADDR_W = 4.
REQ-032 Sub-module reg_mw: MEM/WB register with bubble input, instantiated once.

Verification
REQ-033 ALU op RegWriteM=1, WA3M=5, ALUOutM=0x1234 -> next cycle RegWriteW=1, WA3W=5, ALUOutW=0x1234, StallM never 1.
REQ-034 Load ALUOutM=0x40, MemAck after 3 WAIT cycles with MemRData=0xDEADBEEF -> StallM high 4 cycles, then ReadDataW=0xDEADBEEF, MemToRegW=1; bubbles before.
REQ-035 Store ALUOutM=0x80, WriteDataM=0xA5A5A5A5, ack on first WAIT cycle -> MemReq=1, MemWe=1 one cycle, MemWData=0xA5A5A5A5, RegWriteW=0.
REQ-036 RST_N low during WAIT -> next cycle MemReq=0, all W outputs 0, MemAck one cycle later ignored.
REQ-037 MEM_TIMEOUT_EN, TIMEOUT=16, no MemAck -> after 16 WAIT cycles MemReq=0, StallM=0, MemErr=1 until reset.
REQ-038 Back-to-back loads with immediate ack -> each occupies 2 cycles, two distinct writebacks, no duplicates.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory pipeline stage
package mem_stage_pkg;

    localparam int REG_ADDR_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/reg_mw.sv
// rtl/reg_mw.sv - MEM/WB pipeline register with bubble insertion
// Ports: CLK, RST_N (sync active-low), bubble (load zeros instead of M fields),
//        M-stage controls/data in, W-stage controls/data out.
module reg_mw
    import mem_stage_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  bubble,
    input  logic                  PCSrcM,
    input  logic                  RegWriteM,
    input  logic                  MemToRegM,
    input  logic [REG_ADDR_W-1:0] WA3M,
    input  logic [SIZE-1:0]       ReadDataM,
    input  logic [SIZE-1:0]       ALUOutM,
    output logic                  PCSrcW,
    output logic                  RegWriteW,
    output logic                  MemToRegW,
    output logic [REG_ADDR_W-1:0] WA3W,
    output logic [SIZE-1:0]       ReadDataW,
    output logic [SIZE-1:0]       ALUOutW
);

    always_ff @(posedge CLK) begin
        if (!RST_N || bubble) begin
            PCSrcW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
            WA3W      <= '0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
        end else begin
            PCSrcW    <= PCSrcM;
            RegWriteW <= RegWriteM;
            MemToRegW <= MemToRegM;
            WA3W      <= WA3M;
            ReadDataW <= ReadDataM;
            ALUOutW   <= ALUOutM;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - M pipeline stage: data-memory handshake, stall generation, MEM/WB register
// Ports: CLK, RST_N (sync active-low); M-stage controls/data from EX/MEM;
//        memory request MemReq/MemWe/MemAddr/MemWData, response MemRData/MemAck;
//        StallM to upstream; W-stage controls/data; MemErr sticky timeout flag.
// Optional: define MEM_TIMEOUT_EN to abort WAIT after TIMEOUT cycles without MemAck.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  PCSrcM,
    input  logic                  RegWriteM,
    input  logic                  MemToRegM,
    input  logic                  MemWriteM,
    input  logic [REG_ADDR_W-1:0] WA3M,
    input  logic [SIZE-1:0]       ALUOutM,
    input  logic [SIZE-1:0]       WriteDataM,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [SIZE-1:0]       MemAddr,
    output logic [SIZE-1:0]       MemWData,
    input  logic [SIZE-1:0]       MemRData,
    input  logic                  MemAck,
    output logic                  StallM,
    output logic                  PCSrcW,
    output logic                  RegWriteW,
    output logic                  MemToRegW,
    output logic [REG_ADDR_W-1:0] WA3W,
    output logic [SIZE-1:0]       ReadDataW,
    output logic [SIZE-1:0]       ALUOutW,
    output logic                  MemErr
);

    state_t          state;
    state_t          next_state;
    logic            mem_op;
    logic            ack_in_wait;
    logic            timeout_hit;
    logic [SIZE-1:0] read_data_m;

    assign mem_op      = MemToRegM | MemWriteM;
    // MemAck outside WAIT is a stray pulse and must not complete anything.
    assign ack_in_wait = (state == WAIT) && MemAck;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;
    logic          mem_err;

    // Fires on the TIMEOUT-th WAIT cycle without an ack; an ack that same cycle wins.
    assign timeout_hit = (state == WAIT) && !MemAck && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            if ((state == WAIT) && !MemAck && !timeout_hit) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (timeout_hit) begin
                mem_err <= 1'b1;
            end
        end
    end

    assign MemErr = mem_err;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign MemErr         = 1'b0;
`endif

    assign StallM = ((state == IDLE) && mem_op) ||
                    ((state == WAIT) && !MemAck && !timeout_hit);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (mem_op) next_state = WAIT;
            WAIT: if (MemAck || timeout_hit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= IDLE;
            MemReq <= 1'b0;
        end else begin
            state  <= next_state;
            MemReq <= (next_state == WAIT);
        end
    end

    // EX/MEM is frozen by StallM, so these stay stable for the whole request.
    assign MemWe    = MemWriteM;
    assign MemAddr  = ALUOutM;
    assign MemWData = WriteDataM;

    assign read_data_m = (ack_in_wait && MemToRegM) ? MemRData : '0;

    // A timed-out access is dropped, so it writes back a bubble like a stall does.
    reg_mw #(
        .SIZE(SIZE)
    ) u_reg_mw (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bubble    (StallM | timeout_hit),
        .PCSrcM    (PCSrcM),
        .RegWriteM (RegWriteM),
        .MemToRegM (MemToRegM),
        .WA3M      (WA3M),
        .ReadDataM (read_data_m),
        .ALUOutM   (ALUOutM),
        .PCSrcW    (PCSrcW),
        .RegWriteW (RegWriteW),
        .MemToRegW (MemToRegW),
        .WA3W      (WA3W),
        .ReadDataW (ReadDataW),
        .ALUOutW   (ALUOutW)
    );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

    localparam int SIZE    = 32;
    localparam int TIMEOUT = 16;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            PCSrcM, RegWriteM, MemToRegM, MemWriteM;
    logic [3:0]      WA3M;
    logic [SIZE-1:0] ALUOutM, WriteDataM, MemRData;
    logic            MemAck;
    logic            MemReq, MemWe;
    logic [SIZE-1:0] MemAddr, MemWData;
    logic            StallM, PCSrcW, RegWriteW, MemToRegW;
    logic [3:0]      WA3W;
    logic [SIZE-1:0] ReadDataW, ALUOutW;
    logic            MemErr;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mem_stage #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
        .WA3M(WA3M), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemAck(MemAck), .StallM(StallM),
        .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .WA3W(WA3W), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .MemErr(MemErr)
    );

    typedef struct packed {
        logic        pcsrc, regwrite, memtoreg, memwrite;
        logic [3:0]  wa3;
        logic [31:0] alu, wdata;
    } instr_t;

    typedef struct packed {
        logic        pcsrc, regwrite, memtoreg;
        logic [3:0]  wa3;
        logic [31:0] rdata, alu;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr, wdata;
    } req_t;

    instr_t      prog_q[$];
    int          dly_q[$];
    wb_t         got_q[$];
    int          stl_q[$];
    logic [31:0] rd_q[$];
    req_t        req_q[$];
    int          seq_cycles;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_m(input instr_t i);
        PCSrcM = i.pcsrc; RegWriteM = i.regwrite; MemToRegM = i.memtoreg; MemWriteM = i.memwrite;
        WA3M = i.wa3; ALUOutM = i.alu; WriteDataM = i.wdata;
    endtask

    task automatic clear_m();
        instr_t n;
        n = '0;
        set_m(n);
        MemAck = 1'b0;
        MemRData = '0;
    endtask

    function automatic bit w_zero();
        return !PCSrcW && !RegWriteW && !MemToRegW && WA3W == 4'd0 && ReadDataW == '0 && ALUOutW == '0;
    endfunction

    function automatic wb_t w_now();
        wb_t w;
        w.pcsrc = PCSrcW; w.regwrite = RegWriteW; w.memtoreg = MemToRegW;
        w.wa3 = WA3W; w.rdata = ReadDataW; w.alu = ALUOutW;
        return w;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int kind;
        kind = $urandom_range(0, 2);
        i.pcsrc    = 1'($urandom_range(0, 1));
        i.regwrite = 1'($urandom_range(0, 1));
        i.memtoreg = (kind == 1);
        i.memwrite = (kind == 2);
        i.wa3      = 4'($urandom_range(1, 15));
        i.alu      = $urandom | 32'h1;
        i.wdata    = $urandom;
        return i;
    endfunction

    // Upstream + memory environment: presents prog_q in order, holds each while
    // StallM, acks each memory op after dly_q[idx] unacked request cycles.
    task automatic run_seq(input int budget);
        int idx, waits, st;
        idx = 0; waits = 0; st = 0; seq_cycles = 0;
        got_q.delete(); stl_q.delete(); rd_q.delete(); req_q.delete();
        while (idx < prog_q.size() && seq_cycles < budget) begin
            set_m(prog_q[idx]);
            MemAck = 1'b0;
            if (MemReq) begin
                MemAck = (waits == dly_q[idx]);
                waits++;
            end
            MemRData = $urandom;
            #1;
            if (MemAck) begin
                rd_q.push_back(MemRData);
                req_q.push_back({MemWe, MemAddr, MemWData});
            end
            if (StallM) st++;
            else begin
                stl_q.push_back(st);
                st = 0; waits = 0; idx++;
            end
            tick();
            seq_cycles++;
            if (!w_zero()) got_q.push_back(w_now());
        end
        clear_m();
        tick();
        if (!w_zero()) got_q.push_back(w_now());
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        set_m(rand_instr());
        MemAck = 1'b1;
        MemRData = $urandom;
        tick();
        tick();
        total++; if (MemReq !== 1'b0) begin bad++; $display("FAIL reset_memreq got=%b exp=0", MemReq); end
        total++; if (!w_zero()) begin bad++; $display("FAIL reset_w got=%h exp=0", w_now()); end
        total++; if (MemErr !== 1'b0) begin bad++; $display("FAIL reset_memerr got=%b exp=0", MemErr); end
        clear_m();
        #1;
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", StallM); end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        instr_t i;
        i = '0; i.regwrite = 1'b1; i.wa3 = 4'd5; i.alu = 32'h1234;
        set_m(i);
        #1;
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b exp=0", StallM); end
        tick();
        total++;
        if (RegWriteW !== 1'b1 || WA3W !== 4'd5 || ALUOutW !== 32'h1234 || ReadDataW !== 32'h0 || MemToRegW !== 1'b0) begin
            bad++; $display("FAIL alu_wb got=%h exp rw=1 wa3=5 alu=1234", w_now());
        end
        clear_m();
        tick();
    endtask

    task automatic test_load();
        instr_t i;
        int stalls, waits, bubbles_bad;
        bit done, addr_bad;
        i = '0; i.memtoreg = 1'b1; i.regwrite = 1'b1; i.wa3 = 4'd7; i.alu = 32'h40;
        set_m(i);
        stalls = 0; waits = 0; bubbles_bad = 0; done = 0; addr_bad = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            MemAck = MemReq && (waits == 3);
            MemRData = MemAck ? 32'hDEADBEEF : $urandom;
            if (MemReq) begin
                waits++;
                if (MemAddr !== 32'h40 || MemWe !== 1'b0) addr_bad = 1;
            end
            #1;
            if (StallM) stalls++; else done = 1;
            tick();
            if (!done && !w_zero()) bubbles_bad++;
        end
        total++; if (!done) begin bad++; $display("FAIL load_timeout got=stuck exp=complete"); end
        total++; if (stalls !== 4) begin bad++; $display("FAIL load_stalls got=%0d exp=4", stalls); end
        total++; if (addr_bad) begin bad++; $display("FAIL load_req got=wrong exp=addr40 we0"); end
        total++; if (bubbles_bad != 0) begin bad++; $display("FAIL load_bubbles got=%0d exp=0", bubbles_bad); end
        total++;
        if (ReadDataW !== 32'hDEADBEEF || MemToRegW !== 1'b1 || RegWriteW !== 1'b1 || WA3W !== 4'd7 || ALUOutW !== 32'h40) begin
            bad++; $display("FAIL load_wb got=%h exp rdata=deadbeef", w_now());
        end
        clear_m();
        tick();
    endtask

    task automatic test_store();
        instr_t i;
        i = '0; i.memwrite = 1'b1; i.wa3 = 4'd3; i.alu = 32'h80; i.wdata = 32'hA5A5A5A5;
        set_m(i);
        #1;
        total++; if (MemReq !== 1'b0 || StallM !== 1'b1) begin bad++; $display("FAIL store_issue got=req%b stall%b exp=req0 stall1", MemReq, StallM); end
        tick();
        total++;
        if (MemReq !== 1'b1 || MemWe !== 1'b1 || MemWData !== 32'hA5A5A5A5 || MemAddr !== 32'h80) begin
            bad++; $display("FAIL store_req got=req%b we%b wd=%h a=%h exp=1 1 a5a5a5a5 80", MemReq, MemWe, MemWData, MemAddr);
        end
        MemAck = 1'b1;
        MemRData = 32'h12345678;
        #1;
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL store_ack_stall got=%b exp=0", StallM); end
        tick();
        clear_m();
        total++;
        if (MemReq !== 1'b0 || RegWriteW !== 1'b0 || ReadDataW !== 32'h0 || ALUOutW !== 32'h80 || WA3W !== 4'd3 || MemToRegW !== 1'b0) begin
            bad++; $display("FAIL store_wb got=req%b %h exp req0 rw0 rd0 alu80 wa3=3", MemReq, w_now());
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        instr_t i;
        i = '0; i.memtoreg = 1'b1; i.regwrite = 1'b1; i.wa3 = 4'd2; i.alu = 32'h100;
        set_m(i);
        tick();
        total++; if (MemReq !== 1'b1) begin bad++; $display("FAIL rstwait_pre got=%b exp=1", MemReq); end
        RST_N = 1'b0;
        clear_m();
        tick();
        total++; if (MemReq !== 1'b0 || !w_zero()) begin bad++; $display("FAIL rstwait_abort got=req%b %h exp=0", MemReq, w_now()); end
        RST_N = 1'b1;
        i = '0; i.regwrite = 1'b1; i.wa3 = 4'd9; i.alu = 32'h55;
        set_m(i);
        MemAck = 1'b1;
        MemRData = 32'hFFFF0000;
        #1;
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL rstwait_lateack_stall got=%b exp=0", StallM); end
        tick();
        total++;
        if (MemReq !== 1'b0 || ReadDataW !== 32'h0 || WA3W !== 4'd9 || ALUOutW !== 32'h55) begin
            bad++; $display("FAIL rstwait_lateack got=req%b %h exp req0 rd0 wa3=9 alu55", MemReq, w_now());
        end
        clear_m();
        tick();
    endtask

    task automatic test_back_to_back();
        instr_t a, b;
        wb_t ea, eb;
        a = '0; a.memtoreg = 1'b1; a.regwrite = 1'b1; a.wa3 = 4'd4; a.alu = 32'h200;
        b = '0; b.memtoreg = 1'b1; b.regwrite = 1'b1; b.wa3 = 4'd6; b.alu = 32'h204;
        prog_q = '{a, b};
        dly_q  = '{0, 0};
        run_seq(20);
        total++; if (seq_cycles != 4) begin bad++; $display("FAIL b2b_cycles got=%0d exp=4", seq_cycles); end
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL b2b_wb_count got=%0d exp=2", got_q.size()); end
        if (got_q.size() >= 2 && rd_q.size() >= 2) begin
            ea = {1'b0, 1'b1, 1'b1, 4'd4, rd_q[0], 32'h200};
            eb = {1'b0, 1'b1, 1'b1, 4'd6, rd_q[1], 32'h204};
            total++; if (got_q[0] !== ea) begin bad++; $display("FAIL b2b_wb0 got=%h exp=%h", got_q[0], ea); end
            total++; if (got_q[1] !== eb) begin bad++; $display("FAIL b2b_wb1 got=%h exp=%h", got_q[1], eb); end
        end
    endtask

    task automatic test_random();
        int k, exp_st;
        wb_t e;
        req_t er;
        prog_q.delete(); dly_q.delete();
        for (int n = 0; n < 40; n++) begin
            prog_q.push_back(rand_instr());
            dly_q.push_back($urandom_range(0, 3));
        end
        run_seq(400);
        total++; if (got_q.size() != prog_q.size()) begin bad++; $display("FAIL rnd_wb_count got=%0d exp=%0d", got_q.size(), prog_q.size()); end
        total++; if (stl_q.size() != prog_q.size()) begin bad++; $display("FAIL rnd_retired got=%0d exp=%0d", stl_q.size(), prog_q.size()); end
        k = 0;
        for (int j = 0; j < prog_q.size(); j++) begin
            e = {prog_q[j].pcsrc, prog_q[j].regwrite, prog_q[j].memtoreg, prog_q[j].wa3, 32'h0, prog_q[j].alu};
            exp_st = 0;
            if (prog_q[j].memtoreg || prog_q[j].memwrite) begin
                exp_st = 1 + dly_q[j];
                if (k < rd_q.size()) begin
                    if (prog_q[j].memtoreg) e.rdata = rd_q[k];
                    er = {prog_q[j].memwrite, prog_q[j].alu, prog_q[j].wdata};
                    total++; if (req_q[k] !== er) begin bad++; $display("FAIL rnd_req[%0d] got=%h exp=%h", j, req_q[k], er); end
                end
                k++;
            end
            if (j < stl_q.size()) begin
                total++; if (stl_q[j] != exp_st) begin bad++; $display("FAIL rnd_stall[%0d] got=%0d exp=%0d", j, stl_q[j], exp_st); end
            end
            if (j < got_q.size()) begin
                total++; if (got_q[j] !== e) begin bad++; $display("FAIL rnd_wb[%0d] got=%h exp=%h", j, got_q[j], e); end
            end
        end
    endtask

    task automatic test_timeout();
        instr_t i;
        int stalls, reqc;
        bit done;
        i = '0; i.memtoreg = 1'b1; i.regwrite = 1'b1; i.wa3 = 4'd1; i.alu = 32'h300;
        set_m(i);
        MemAck = 1'b0;
`ifdef MEM_TIMEOUT_EN
        stalls = 0; reqc = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (MemReq) reqc++;
            #1;
            if (StallM) stalls++; else done = 1;
            tick();
        end
        clear_m();
        total++; if (!done) begin bad++; $display("FAIL to_release got=stuck exp=released"); end
        total++; if (reqc != TIMEOUT) begin bad++; $display("FAIL to_wait_cycles got=%0d exp=%0d", reqc, TIMEOUT); end
        total++; if (stalls != TIMEOUT) begin bad++; $display("FAIL to_stalls got=%0d exp=%0d", stalls, TIMEOUT); end
        total++; if (MemReq !== 1'b0 || MemErr !== 1'b1 || !w_zero()) begin bad++; $display("FAIL to_abort got=req%b err%b %h exp req0 err1 bubble", MemReq, MemErr, w_now()); end
        for (int c = 0; c < 5; c++) tick();
        total++; if (MemErr !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", MemErr); end
`else
        stalls = 0; reqc = 0; done = 0;
        for (int c = 0; c < 40; c++) begin
            if (MemReq) reqc++;
            #1;
            if (StallM) stalls++;
            tick();
        end
        total++; if (stalls != 40 || reqc != 39) begin bad++; $display("FAIL nto_hold got=stall%0d req%0d exp=40 39", stalls, reqc); end
        total++; if (MemReq !== 1'b1 || MemErr !== 1'b0) begin bad++; $display("FAIL nto_state got=req%b err%b exp=1 0", MemReq, MemErr); end
        done = 1;
`endif
        RST_N = 1'b0;
        clear_m();
        tick();
        RST_N = 1'b1;
        tick();
        total++; if (MemErr !== 1'b0 || MemReq !== 1'b0 || !done) begin bad++; $display("FAIL to_reset got=err%b req%b exp=0 0", MemErr, MemReq); end
    endtask

    initial begin
        RST_N = 1'b0;
        clear_m();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
